uart_rx_monitor: RTL and testbench
==================================

UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 Parameter SYS_CLK_FREQ, default 100000000; system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200; serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 16; received-byte buffer depth, power of 2, minimum 2.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  serial line driven by riscv_top Tx; idle high; asynchronous to clk.
REQ-007 rd_en  input  1  pops the head byte when empty is low.
REQ-008 rd_data  output  8  head byte of the FIFO (first-word-fall-through); valid while empty is low.
REQ-009 empty  output  1  FIFO holds no bytes.
REQ-010 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 frame_err  output  1  sticky; a stop bit was sampled low.
REQ-012 overflow  output  1  sticky; a complete byte was dropped because the FIFO was full.
REQ-013 byte_count  output  32  count of bytes accepted into the FIFO; wraps modulo 2^32.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Tick generator SHALL pulse once every DIV = SYS_CLK_FREQ/(BAUD_RATE*16) clocks (integer division, DIV >= 1), free-running.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: a synchronized low on rx SHALL move the FSM to START and clear the tick counter.
REQ-018 START: after 8 ticks, rx low -> DATA; rx high -> IDLE (glitch rejected, nothing recorded).
REQ-019 DATA: 8 bits SHALL be sampled every 16 ticks, LSB first.
REQ-020 STOP: sampled 16 ticks after the last data bit; high -> byte offered to FIFO; low -> frame_err set, byte discarded; then IDLE in both cases.
REQ-021 Offered byte SHALL be written on the clock after the stop sample; byte_count SHALL increment on that same clock.
REQ-022 Write when full without a same-cycle pop SHALL set overflow, drop the byte and leave byte_count unchanged.
REQ-023 Write and pop on the same cycle while full SHALL both succeed; full stays high.
REQ-024 Write and pop on the same cycle while empty: the pop is ignored and the byte is written.
REQ-025 rd_en while empty SHALL be ignored with no state change.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from an extra pointer bit.
REQ-027 rd_data SHALL update one clock after a pop or after a write into an empty FIFO.
REQ-028 frame_err and overflow SHALL clear only on rst.

Reset
REQ-029 rst SHALL force: FSM IDLE, tick and bit counters 0, synchronizer flops 1, FIFO pointers 0, empty=1, full=0, rd_data=0, frame_err=0, overflow=0, byte_count=0.
REQ-030 rst asserted mid-frame SHALL abandon the partial byte; after release the FSM SHALL wait for the next falling edge.

Structure
REQ-031 FSM state encodings and the oversample factor (16) SHALL live in shared package uart_pkg.
REQ-032 Tick generator SHALL be sub-module uart_baud_tick (ports clk, rst, tick).
REQ-033 FIFO storage and pointers SHALL stay inline in uart_rx_monitor.

Verification (SYS_CLK_FREQ=1600000, BAUD_RATE=10000: DIV=10, 160 clocks/bit)
REQ-034 Send 0x41 with a valid stop bit -> empty falls, rd_data=0x41, byte_count=1, frame_err=0.
REQ-035 Pulse rx low for 40 clocks, then idle -> no byte, FSM back in IDLE, byte_count=0.
REQ-036 Send 0x55 with the stop bit held low -> frame_err=1, empty stays 1, byte_count=0.
REQ-037 FIFO_DEPTH=4, send 0x01..0x05 with no pops -> full=1, overflow=1, byte_count=4; pops return 0x01..0x04.
REQ-038 With a full FIFO, pop exactly on the write cycle of a 6th byte 0x06 -> overflow stays 0, byte_count=5, last pop returns 0x06.
REQ-039 Assert rst during data bit 3 of 0xA5, release, then send 0x3C -> only 0x3C is received, byte_count=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive monitor: receiver FSM states and
// the oversampling factor used by both the tick generator and the receiver.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;
endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clock pulse every SYS_CLK_FREQ/(BAUD_RATE*16) clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through
// byte FIFO, plus sticky error flags and an accepted-byte counter.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic        frame_err,
  output logic        overflow,
  output logic [31:0] byte_count,
  output rx_state_e   state
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0]        sync;
  logic [1:0]        sync_vld;
  logic              rx_s;
  logic              armed;
  logic              tick;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              wr_req;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [AW:0]       level;
  logic [AW-1:0]     head_nxt;
  logic              pop;
  logic              push;

  uart_baud_tick #(
    .SYS_CLK_FREQ(SYS_CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // sync_vld marks when the synchronizer holds real line samples rather than reset ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= 2'b11;
      sync_vld <= 2'b00;
    end else begin
      sync     <= {sync[0], rx};
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign rx_s = sync[1];

  // A start needs a genuine high seen in IDLE first, so only a true falling edge begins a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      wr_req    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_req <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            armed    <= 1'b0;
          end else if (sync_vld[1] && rx_s) begin
            armed <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s) wr_req <= 1'b1;
              else      frame_err <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level    = wptr - rptr;
  assign head_nxt = rptr[AW-1:0] + AW'(1);
  assign pop      = rd_en && !empty;
  assign push     = wr_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= shift;
  end

  // rd_data is the registered head: loaded from the incoming byte when it becomes the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      rd_data    <= '0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (push) begin
        wptr       <= wptr + (AW+1)'(1);
        byte_count <= byte_count + 32'd1;
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (wr_req && full && !pop) overflow <= 1'b1;
      if (push && (empty || (pop && level == (AW+1)'(1)))) begin
        rd_data <= shift;
      end else if (pop && level != (AW+1)'(1)) begin
        rd_data <= mem[head_nxt];
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed and randomized frames against a queue-based model of the receiver and FIFO.
module tb_uart_rx_monitor;
  import uart_pkg::*;

  localparam int SYS   = 1600000;
  localparam int BAUD  = 10000;
  localparam int DEPTH = 4;
  localparam int BIT   = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic        frame_err;
  logic        overflow;
  logic [31:0] byte_count;
  rx_state_e   state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  int unsigned exp_count;
  bit          exp_ferr;
  bit          exp_ovf;

  uart_rx_monitor #(
    .SYS_CLK_FREQ(SYS),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .frame_err (frame_err),
    .overflow  (overflow),
    .byte_count(byte_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_count = 0;
    exp_ferr  = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  // A completed frame: good stop bit queues the byte if there is room
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      exp_ferr = 1'b1;
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
      exp_count++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pop_on_write);
    bit seen_stop;
    bit popped;
    seen_stop = 1'b0;
    popped    = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_ok;
    for (int c = 0; c < BIT; c++) begin
      @(negedge clk);
      rd_en = 1'b0;
      if (pop_on_write && !popped) begin
        if (seen_stop && state == IDLE) begin
          check("pow_head", 32'(rd_data), 32'(exp_q[0]));
          rd_en  = 1'b1;
          popped = 1'b1;
          void'(exp_q.pop_front());
        end else if (state == STOP) begin
          seen_stop = 1'b1;
        end
      end
    end
    rd_en = 1'b0;
    rx    = 1'b1;
    if (pop_on_write) check("pow_hit", 32'(popped), 32'd1);
    model_frame(b, stop_ok);
    repeat (BIT) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    if (exp_q.size() > 0) begin
      check({tag, "_data"}, 32'(rd_data), 32'(exp_q[0]));
      rd_en = 1'b1;
      void'(exp_q.pop_front());
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    if (exp_q.size() > 0) check({tag, "_head"}, 32'(rd_data), 32'(exp_q[0]));
    check({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_count"}, byte_count, exp_count);
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    int         npop;

    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    apply_reset();

    // Reset values
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_count", byte_count, 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));

    // Single good byte
    send_frame(8'h41, 1'b1, 1'b0);
    check_all("b41");
    pop_check("b41_pop");
    check_all("b41_after");

    // Short low glitch must be rejected
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch_in_start", 32'(state), 32'(START));
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_state", 32'(state), 32'(IDLE));
    check_all("glitch");

    // Stop bit low sets the sticky frame error
    apply_reset();
    send_frame(8'h55, 1'b0, 1'b0);
    check_all("ferr");
    repeat (BIT) @(negedge clk);
    check("ferr_sticky", 32'(frame_err), 32'd1);

    // Overfill a 4-deep FIFO
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, 1'b0);
    end
    check_all("ovf");
    for (int i = 0; i < 4; i++) pop_check("ovf_pop");
    check_all("ovf_drained");

    // Pop on the exact write cycle of a full FIFO
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, 1'b0);
    end
    check_all("pow_full");
    send_frame(8'h06, 1'b1, 1'b1);
    check_all("pow");
    for (int i = 0; i < 4; i++) pop_check("pow_pop");
    check_all("pow_drained");

    // Reset in the middle of data bit 3 of 0xA5
    apply_reset();
    b = 8'hA5;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[3];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("midrst_state", 32'(state), 32'(IDLE));
    check("midrst_empty", 32'(empty), 32'd1);
    repeat (BIT) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_all("midrst");
    pop_check("midrst_pop");

    // Randomized frames with random pops between them
    apply_reset();
    for (int n = 0; n < 12; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, 1'b0);
      check_all("rand");
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) pop_check("rand_pop");
    end
    while (exp_q.size() > 0) pop_check("rand_drain");
    check_all("rand_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
